// File: rtl/argmax_pkg.sv
// Shared FSM state encoding and default sizing for the argmax/argmin streamer.
package argmax_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int DEF_N_CLASSES = 10;
  localparam int DEF_DATA_W    = 32;

endpackage

// File: rtl/index_to_onehot.sv
// Binary index to one-hot decode; purely combinational, no flow control.
module index_to_onehot #(
  parameter  int N     = 10,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/argmax_stream.sv
// Streams one frame of signed scores and reports the arg-max (or arg-min) index, score and length.
// Result registered 1 cycle after the frame-ending score; input stalls while a result awaits out_ready.
module argmax_stream
  import argmax_pkg::*;
#(
  parameter  int N_CLASSES = DEF_N_CLASSES,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int FIND_MIN  = 0,
  localparam int IDX_W     = $clog2(N_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_CLASSES-1:0]     out_onehot,
  output logic [IDX_W-1:0]         out_index,
  output logic signed [DATA_W-1:0] out_best,
  output logic [IDX_W:0]           out_len
);

  state_t                     state_q, state_d;
  logic                       rdy_q;
  logic                       vld_q;
  logic [IDX_W-1:0]           pos_q;
  logic [IDX_W-1:0]           idx_q;
  logic signed [DATA_W-1:0]   best_q;

  logic                       xfer;
  logic                       frame_end;
  logic                       better;
  logic                       take;
  logic signed [DATA_W-1:0]   cand_best;
  logic [IDX_W-1:0]           cand_idx;
  logic [N_CLASSES-1:0]       cand_onehot;

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;

  assign xfer      = in_valid && rdy_q;
  assign frame_end = xfer && (in_last || (pos_q == IDX_W'(N_CLASSES - 1)));
  assign better    = (FIND_MIN != 0) ? (in_data < best_q) : (in_data > best_q);
  // First score of a frame always wins so the running best never compares against stale data.
  assign take      = xfer && ((pos_q == '0) || better);
  assign cand_best = take ? in_data : best_q;
  assign cand_idx  = take ? pos_q : idx_q;

  index_to_onehot #(.N(N_CLASSES)) u_dec (
    .idx    (cand_idx),
    .onehot (cand_onehot)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (frame_end) state_d = DONE;
      DONE:    if (vld_q && out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clear) state_d = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ACCUM);
      vld_q   <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q      <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      out_onehot <= '0;
      out_index  <= '0;
      out_best   <= '0;
      out_len    <= '0;
    end else if (clear) begin
      pos_q      <= '0;
      out_onehot <= '0;
      out_index  <= '0;
      out_best   <= '0;
      out_len    <= '0;
    end else begin
      if (xfer) begin
        pos_q  <= frame_end ? '0 : pos_q + IDX_W'(1);
        best_q <= cand_best;
        idx_q  <= cand_idx;
      end
      if (frame_end) begin
        out_onehot <= cand_onehot;
        out_index  <= cand_idx;
        out_best   <= cand_best;
        out_len    <= {1'b0, pos_q} + (IDX_W + 1)'(1);
      end else if (vld_q && out_ready) begin
        out_onehot <= '0;
        out_index  <= '0;
        out_best   <= '0;
        out_len    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench: table of frames for argmax/argmin instances plus backpressure, clear and reset sequences.
module tb_argmax_stream;

  localparam int MINI = 32'sh8000_0000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic               in_valid;
  logic signed [31:0] in_data;
  logic               in_last;
  logic               out_ready;

  logic               rdy_max, rdy_min, ov_max, ov_min;
  logic [9:0]         oh_max, oh_min;
  logic [3:0]         idx_max, idx_min;
  logic signed [31:0] best_max, best_min;
  logic [4:0]         len_max, len_min;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  argmax_stream dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy_max), .in_data(in_data), .in_last(in_last),
    .out_valid(ov_max), .out_ready(out_ready), .out_onehot(oh_max),
    .out_index(idx_max), .out_best(best_max), .out_len(len_max)
  );

  argmax_stream #(.N_CLASSES(10), .DATA_W(32), .FIND_MIN(1)) dut_min (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy_min), .in_data(in_data), .in_last(in_last),
    .out_valid(ov_min), .out_ready(out_ready), .out_onehot(oh_min),
    .out_index(idx_min), .out_best(best_min), .out_len(len_min)
  );

  typedef struct {
    int   n;
    int   last_at;   // -1: rely on the position counter to end the frame
    bit   use_min;
    int   sc[10];
    int   exp_idx;
    int   exp_best;
    int   exp_len;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the score was accepted.
  task automatic send(input logic [31:0] d, input logic l);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!rdy_max && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", {63'd0, rdy_max}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit hs, input string tag);
    logic [9:0]         eoh;
    logic [9:0]         oh;
    logic [3:0]         ix;
    logic signed [31:0] bs;
    logic [4:0]         ln;
    logic               ov;
    for (int i = 0; i < v.n; i++) send(v.sc[i], i == v.last_at);
    eoh = 10'd1 << v.exp_idx;
    ov  = v.use_min ? ov_min   : ov_max;
    oh  = v.use_min ? oh_min   : oh_max;
    ix  = v.use_min ? idx_min  : idx_max;
    bs  = v.use_min ? best_min : best_max;
    ln  = v.use_min ? len_min  : len_max;
    check({tag, "_valid"},  {63'd0, ov}, 64'd1);
    check({tag, "_index"},  64'(ix), 64'(v.exp_idx));
    check({tag, "_best"},   64'(bs), 64'(v.exp_best));
    check({tag, "_len"},    64'(ln), 64'(v.exp_len));
    check({tag, "_onehot"}, 64'(oh), 64'(eoh));
    check({tag, "_rdy_lo"}, {63'd0, rdy_max}, 64'd0);
    if (hs) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_hs_valid"},  {63'd0, ov_max}, 64'd0);
      check({tag, "_hs_rdy"},    {63'd0, rdy_max}, 64'd1);
      check({tag, "_hs_onehot"}, 64'(oh_max), 64'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  {63'd0, ov_max}, 64'd0);
    check({tag, "_rdy"},    {63'd0, rdy_max}, 64'd0);
    check({tag, "_onehot"}, 64'(oh_max), 64'd0);
    check({tag, "_index"},  64'(idx_max), 64'd0);
    check({tag, "_best"},   64'(best_max), 64'd0);
    check({tag, "_len"},    64'(len_max), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t t;
    vecs[0] = '{n:10, last_at:9,  use_min:0, sc:'{3,-7,12,0,5,12,1,2,9,4},        exp_idx:2, exp_best:12,         exp_len:10};
    vecs[1] = '{n:10, last_at:-1, use_min:0, sc:'{MINI,MINI,MINI,MINI,MINI,MINI,MINI,MINI,MINI,MINI},
                exp_idx:0, exp_best:MINI, exp_len:10};
    vecs[2] = '{n:4,  last_at:3,  use_min:1, sc:'{4,-1,-1,8,0,0,0,0,0,0},         exp_idx:1, exp_best:-1,         exp_len:4};
    vecs[3] = '{n:10, last_at:9,  use_min:0, sc:'{9,8,7,6,5,4,3,2,1,0},           exp_idx:0, exp_best:9,          exp_len:10};
    vecs[4] = '{n:2,  last_at:1,  use_min:0, sc:'{-5,-3,0,0,0,0,0,0,0,0},         exp_idx:1, exp_best:-3,         exp_len:2};
    vecs[5] = '{n:1,  last_at:0,  use_min:0, sc:'{7,0,0,0,0,0,0,0,0,0},           exp_idx:0, exp_best:7,          exp_len:1};
    vecs[6] = '{n:10, last_at:-1, use_min:1, sc:'{5,6,7,8,9,10,11,12,13,14},      exp_idx:0, exp_best:5,          exp_len:10};
    vecs[7] = '{n:4,  last_at:3,  use_min:1, sc:'{3,1,1,1,0,0,0,0,0,0},           exp_idx:1, exp_best:1,          exp_len:4};
    vecs[8] = '{n:3,  last_at:2,  use_min:0, sc:'{-1,2147483647,MINI,0,0,0,0,0,0,0},
                exp_idx:1, exp_best:2147483647, exp_len:3};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_rdy_before_edge", {63'd0, rdy_max}, 64'd0);
    @(negedge clk);
    check("rel_rdy_after_edge", {63'd0, rdy_max}, 64'd1);

    foreach (vecs[k]) run_vec(vecs[k], 1'b1, $sformatf("vec%0d", k));

    // Backpressure: result held, in_valid pulses (with in_last) ignored while DONE.
    run_vec(vecs[0], 1'b0, "bp");
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      in_data  = 100;
      in_last  = 1'b1;
      @(negedge clk);
      check("bp_hold_valid", {63'd0, ov_max}, 64'd1);
      check("bp_hold_rdy",   {63'd0, rdy_max}, 64'd0);
      check("bp_hold_index", 64'(idx_max), 64'd2);
      check("bp_hold_best",  64'(best_max), 64'd12);
      check("bp_hold_len",   64'(len_max), 64'd10);
      check("bp_hold_oh",    64'(oh_max), 64'h4);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 50;
    in_last   = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_after_hs_valid", {63'd0, ov_max}, 64'd0);
    check("bp_after_hs_rdy",   {63'd0, rdy_max}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_next_valid", {63'd0, ov_max}, 64'd1);
    check("bp_next_best",  64'(best_max), 64'd50);
    check("bp_next_len",   64'(len_max), 64'd1);
    check("bp_next_index", 64'(idx_max), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Clear after 4 scores, with a simultaneous transfer that must be dropped.
    for (int i = 0; i < 4; i++) send(32'(100 * (i + 1)), 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 1000;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_valid", {63'd0, ov_max}, 64'd0);
    check("clr_rdy",   {63'd0, rdy_max}, 64'd1);
    t = '{n:3, last_at:2, use_min:0, sc:'{1,9,2,0,0,0,0,0,0,0}, exp_idx:1, exp_best:9, exp_len:3};
    run_vec(t, 1'b1, "clr_frame");

    // Reset mid-frame: partial frame lost, counter restarts.
    for (int i = 0; i < 3; i++) send(32'(20 + i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_zero("rst_mid_frame");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t = '{n:2, last_at:1, use_min:0, sc:'{7,3,0,0,0,0,0,0,0,0}, exp_idx:0, exp_best:7, exp_len:2};
    run_vec(t, 1'b1, "post_rst");

    // Reset while a result is waiting.
    run_vec(vecs[3], 1'b0, "pre_rst_done");
    #3 rst_n = 1'b0;
    #1;
    check_zero("rst_mid_done");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_done_rdy", {63'd0, rdy_max}, 64'd1);
    check("rst_done_valid", {63'd0, ov_max}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
